// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC front end, counter and readout stages:
// FSM state encoding and default widths.
package tdc_pkg;

  // Default configuration shared by the TDC stages
  localparam int unsigned TDC_SYNC_STAGES = 2;
  localparam int unsigned TDC_TMO_W       = 16;
  localparam int unsigned TDC_TIMEOUT     = 1000;
  localparam int unsigned TDC_DEAD_CYCLES = 8;
  localparam int unsigned TDC_CNT_W       = 16;

  // Sequencer state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_STOP = 2'd1;
  localparam logic [1:0] ST_DEAD      = 2'd2;

endpackage

// File: rtl/tdc_sync_edge.sv
// Synchroniser plus rising-edge detector for one asynchronous discriminator
// level. Chain and history flop reset to 1 so a level already high when reset
// is released does not look like a fresh edge.
module tdc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // Shift the async level through the synchroniser and keep last synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      hist_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronised level; the consumer registers it
  assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/tdc_pulse_sequencer.sv
// TDC front end: turns synchronised start/stop discriminator edges into clean
// one-cycle start_pulse/stop_pulse, enforcing start-before-stop ordering, a
// measurement timeout and a post-stop dead time. Saturating event counters
// are kept for run monitoring.
module tdc_pulse_sequencer
  import tdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = TDC_SYNC_STAGES,
  parameter int unsigned TMO_W          = TDC_TMO_W,
  parameter int unsigned TIMEOUT_CYCLES = TDC_TIMEOUT,
  parameter int unsigned DEAD_CYCLES    = TDC_DEAD_CYCLES,
  parameter int unsigned CNT_W          = TDC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cnt_clr,
  input  logic             start_in,
  input  logic             stop_in,
  output logic             start_pulse,
  output logic             stop_pulse,
  output logic             forced_stop,
  output logic             busy,
  output logic [CNT_W-1:0] n_start,
  output logic [CNT_W-1:0] n_stop,
  output logic [CNT_W-1:0] n_forced
);

  // Dead-time counter only needs to reach DEAD_CYCLES-1
  localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  logic              start_rise_s;
  logic              stop_rise_s;
  logic [1:0]        state_r, state_s;
  logic [TMO_W-1:0]  timer_r, timer_s;
  logic [DEAD_W-1:0] dead_r, dead_s;
  logic              start_s, stop_s, forced_s;
  logic              start_pulse_r, stop_pulse_r, forced_stop_r, busy_r;
  logic [CNT_W-1:0]  n_start_r, n_stop_r, n_forced_r;

  // Saturating increment: counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  tdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (start_in),
    .rise (start_rise_s)
  );

  tdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (stop_in),
    .rise (stop_rise_s)
  );

  // Next-state, timer and pulse decision for the measurement sequencer
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    dead_s   = dead_r;
    start_s  = 1'b0;
    stop_s   = 1'b0;
    forced_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A stop edge in the same cycle as the start is simply dropped
        if (enable && start_rise_s) begin
          start_s = 1'b1;
          timer_s = {TMO_W{1'b0}};
          state_s = ST_WAIT_STOP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_STOP: begin
        // Abort beats a real stop, and a real stop beats the timeout
        if (!enable) begin
          stop_s   = 1'b1;
          forced_s = 1'b1;
          timer_s  = {TMO_W{1'b0}};
          dead_s   = {DEAD_W{1'b0}};
          state_s  = ST_DEAD;
        end else if (stop_rise_s) begin
          stop_s   = 1'b1;
          forced_s = 1'b0;
          timer_s  = {TMO_W{1'b0}};
          dead_s   = {DEAD_W{1'b0}};
          state_s  = ST_DEAD;
        end else if (timer_r == TMO_LAST) begin
          stop_s   = 1'b1;
          forced_s = 1'b1;
          timer_s  = {TMO_W{1'b0}};
          dead_s   = {DEAD_W{1'b0}};
          state_s  = ST_DEAD;
        end else begin
          timer_s  = timer_r + TMO_W'(1);
        end
      end
      ST_DEAD: begin
        if (dead_r == DEAD_LAST) begin
          dead_s  = {DEAD_W{1'b0}};
          state_s = ST_IDLE;
        end else begin
          dead_s  = dead_r + DEAD_W'(1);
        end
      end
      default: begin
        timer_s = {TMO_W{1'b0}};
        dead_s  = {DEAD_W{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered one-cycle pulses/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TMO_W{1'b0}};
      dead_r        <= {DEAD_W{1'b0}};
      start_pulse_r <= 1'b0;
      stop_pulse_r  <= 1'b0;
      forced_stop_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      dead_r        <= dead_s;
      start_pulse_r <= start_s;
      stop_pulse_r  <= stop_s;
      forced_stop_r <= stop_s & forced_s;
      busy_r        <= (state_s != ST_IDLE);
    end
  end

  // Saturating event counters; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_start_r  <= {CNT_W{1'b0}};
      n_stop_r   <= {CNT_W{1'b0}};
      n_forced_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      n_start_r  <= {CNT_W{1'b0}};
      n_stop_r   <= {CNT_W{1'b0}};
      n_forced_r <= {CNT_W{1'b0}};
    end else begin
      if (start_s) begin
        n_start_r <= sat_inc(n_start_r);
      end
      if (stop_s && !forced_s) begin
        n_stop_r <= sat_inc(n_stop_r);
      end
      if (stop_s && forced_s) begin
        n_forced_r <= sat_inc(n_forced_r);
      end
    end
  end

  assign start_pulse = start_pulse_r;
  assign stop_pulse  = stop_pulse_r;
  assign forced_stop = forced_stop_r;
  assign busy        = busy_r;
  assign n_start     = n_start_r;
  assign n_stop      = n_stop_r;
  assign n_forced    = n_forced_r;

endmodule
